// File: rtl/adder_pkg.sv
// adder_pkg
// Shared definitions for the chunked wide adder and its N-bit datapath:
//   - state_e        : control FSM encoding (ST_IDLE=0, ST_RUN=1)
//   - ADDER_DEFAULT_N: default chunk width in bits
//   - ADDER_DEFAULT_K: default number of chunks
//   - idx_width()    : index width for a K-entry chunk counter (min 1 bit)
package adder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int ADDER_DEFAULT_N = 8;
  localparam int ADDER_DEFAULT_K = 4;

  // ceil(log2(v)), but never less than 1 so a K=1 counter still has a bit.
  function automatic int idx_width(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/faNbit_full_adder.sv
// faNbit_full_adder
// Purely combinational N-bit ripple-carry adder: {cout, S} = X + Y + cin.
// Ports:
//   X    in  N  addend
//   Y    in  N  addend
//   cin  in  1  carry into bit 0
//   S    out N  sum bits
//   cout out 1  carry out of bit N-1
module faNbit_full_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         cin,
  output logic [N-1:0] S,
  output logic         cout
);

  // The ripple carry lives in a procedural variable so the chain is
  // evaluated bit by bit inside one block rather than as a self-feeding net.
  always_comb begin
    logic carry;
    carry = cin;
    S     = '0;
    for (int i = 0; i < N; i++) begin
      S[i]  = X[i] ^ Y[i] ^ carry;
      carry = (X[i] & Y[i]) | (carry & (X[i] ^ Y[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/chunked_wide_adder.sv
// chunked_wide_adder
// Multi-cycle W = N*K bit adder. One N-bit chunk is added per clock through a
// single faNbit_full_adder; the chunk carry is registered between cycles.
//
// Handshake: start is sampled only while busy=0 (state IDLE). An accepted
// start captures a, b and cin; busy is then high for exactly K cycles and
// done pulses for one cycle on the cycle after the last chunk, at which point
// sum/cout/overflow have just been updated. start is accepted again in the
// done cycle, so back-to-back operations take K+1 cycles each. start while
// busy=1 is ignored. Results hold until the next completion.
//
// Ports:
//   clk      in  1  clock, rising edge
//   rst_n    in  1  asynchronous active-low reset
//   start    in  1  request a new add
//   a, b     in  W  operands, captured on accepted start
//   cin      in  1  carry-in, captured on accepted start
//   busy     out 1  chunks in progress
//   done     out 1  one-cycle completion pulse
//   sum      out W  held result
//   cout     out 1  held carry out of bit W-1
//   overflow out 1  held two's-complement overflow
module chunked_wide_adder
  import adder_pkg::*;
#(
  parameter int N = ADDER_DEFAULT_N,
  parameter int K = ADDER_DEFAULT_K
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N*K-1:0]   a,
  input  logic [N*K-1:0]   b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [N*K-1:0]   sum,
  output logic             cout,
  output logic             overflow
);

  localparam int W     = N * K;
  localparam int IDX_W = idx_width(K);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  // Operands and the working sum are kept as K chunks of N bits so the
  // current chunk is selected with a plain index.
  state_e                  state_q, state_d;
  logic [K-1:0][N-1:0]     a_q, a_d;
  logic [K-1:0][N-1:0]     b_q, b_d;
  logic [K-1:0][N-1:0]     work_q, work_d;
  logic                    carry_q, carry_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [K-1:0][N-1:0]     sum_q, sum_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;

  logic [N-1:0]            fa_s;
  logic                    fa_cout;

  faNbit_full_adder #(
    .N (N)
  ) u_fa (
    .X    (a_q[idx_q]),
    .Y    (b_q[idx_q]),
    .cin  (carry_q),
    .S    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        work_d[idx_q] = fa_s;
        carry_d       = fa_cout;
        if (idx_q == LAST_IDX) begin
          // work_d already has the final chunk merged in, so the result
          // register is written in one step and never shows partial chunks.
          sum_d   = work_d;
          cout_d  = fa_cout;
          ovf_d   = (a_q[K-1][N-1] == b_q[K-1][N-1]) &&
                    (work_d[K-1][N-1] != a_q[K-1][N-1]);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_wide_adder.sv
// tb_chunked_wide_adder
// Directed and randomized checks of chunked_wide_adder (N=8, K=4) against an
// arithmetic reference model: {overflow, cout, sum} from wide integer math.
module tb_chunked_wide_adder;

  localparam int N   = 8;
  localparam int K   = 4;
  localparam int W   = N * K;
  localparam int TMO = 40;

  // ---------------- clock / reset ----------------
  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  always #5 clk = ~clk;

  chunked_wide_adder #(
    .N (N),
    .K (K)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  // ---------------- scoreboard state ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W+1:0] exp_q[$];   // {overflow, cout, sum}
  logic [W-1:0] held_sum;   // result the outputs should be holding

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         c);
    logic [W:0] u;
    longint     sx;
    longint     lim;
    logic       ov;
    u   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    sx  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    lim = longint'(1) <<< (W - 1);
    ov  = (sx > lim - 1) || (sx < -lim);
    return {ov, u[W], u[W-1:0]};
  endfunction

  // ---------------- driver ----------------
  // Called #1 after a rising edge with the DUT idle. Pulses start, then waits
  // (bounded) for done. lat counts edges after the accepting edge; busy_cnt
  // counts cycles busy was seen; busy_sum records sum seen while busy.
  // With poke set, junk start requests are thrown in while busy.
  task automatic drive_op(input  logic [W-1:0] av,
                          input  logic [W-1:0] bv,
                          input  logic         c,
                          input  bit           poke,
                          output int           lat,
                          output int           busy_cnt,
                          output logic [W-1:0] busy_sum);
    a = av; b = bv; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    busy_sum = sum;
    while (!done && lat < TMO) begin
      if (busy) busy_cnt++;
      if (sum !== busy_sum) busy_sum = sum;
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        a     = $urandom();
        b     = $urandom();
        cin   = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, cout, overflow} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got busy/done/cout/ovf=%b required 0000",
               {busy, done, cout, overflow});
    end
    n_cmp++;
    if (sum !== '0) begin
      n_err++;
      $display("FAIL reset_sum: got %h required 0", sum);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b done=%b required 0 0", busy, done);
    end
    held_sum = '0;
  endtask

  // Directed vectors first, then randomized ones with corner biasing.
  task automatic test_arith(input int n_rand);
    logic [W-1:0] ta[$];
    logic [W-1:0] tb[$];
    logic         tc[$];
    logic [W-1:0] busy_sum;
    logic [W+1:0] exp;
    int           lat, busy_cnt;
    ta = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678};
    tb = '{32'h0000_0001, 32'h0000_0001, 32'h1111_1111};
    tc = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < n_rand; i++) begin
      case ($urandom_range(0, 3))
        0:       ta.push_back({W{1'b1}});
        1:       ta.push_back({1'b1, {(W-1){1'b0}}});
        default: ta.push_back($urandom());
      endcase
      case ($urandom_range(0, 3))
        0:       tb.push_back({1'b0, {(W-1){1'b1}}});
        1:       tb.push_back({1'b1, {(W-1){1'b0}}});
        default: tb.push_back($urandom());
      endcase
      tc.push_back(1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < ta.size(); i++) begin
      exp_q.push_back(ref_add(ta[i], tb[i], tc[i]));
      drive_op(ta[i], tb[i], tc[i], (i >= 3), lat, busy_cnt, busy_sum);
      n_cmp++;
      if (lat !== K) begin
        n_err++;
        $display("FAIL op%0d_latency: got %0d edges required %0d", i, lat, K);
      end
      n_cmp++;
      if (busy_cnt !== K) begin
        n_err++;
        $display("FAIL op%0d_busy_cycles: got %0d required %0d", i, busy_cnt, K);
      end
      n_cmp++;
      if (busy_sum !== held_sum) begin
        n_err++;
        $display("FAIL op%0d_sum_held_while_busy: got %h required %h", i, busy_sum, held_sum);
      end
      exp = exp_q.pop_front();
      n_cmp++;
      if ({overflow, cout, sum} !== exp) begin
        n_err++;
        $display("FAIL op%0d_result a=%h b=%h cin=%b: got ovf=%b cout=%b sum=%h required ovf=%b cout=%b sum=%h",
                 i, ta[i], tb[i], tc[i], overflow, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
      end
      held_sum = exp[W-1:0];
      // done must drop after a single cycle; idle gap of random length
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL op%0d_done_pulse: got done=%b busy=%b after 1 cycle required 0 0", i, done, busy);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  task automatic test_ignore_start();
    logic [W+1:0] exp;
    int           lat, extra_done, extra_busy;
    exp = ref_add(32'd5, 32'd7, 1'b0);
    a = 32'd5; b = 32'd7; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // edge t accepts
    start = 1'b0;
    @(posedge clk); #1;                       // edge t+1
    a = 32'd100; b = 32'd100; start = 1'b1;   // sampled at t+2 while busy
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (!done && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== K) begin
      n_err++;
      $display("FAIL ignore_latency: got %0d required %0d", lat, K);
    end
    n_cmp++;
    if ({overflow, cout, sum} !== exp) begin
      n_err++;
      $display("FAIL ignore_result: got sum=%h cout=%b ovf=%b required sum=%h", sum, cout, overflow, exp[W-1:0]);
    end
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    n_cmp++;
    if (extra_done !== 0 || extra_busy !== 0) begin
      n_err++;
      $display("FAIL ignore_no_second_op: got %0d done and %0d busy cycles required 0 0", extra_done, extra_busy);
    end
    held_sum = exp[W-1:0];
  endtask

  task automatic test_reset_mid();
    logic [W+1:0] exp;
    logic [W-1:0] busy_sum;
    int           lat, busy_cnt, late_done;
    a = 32'hDEAD_0000; b = 32'h0000_BEEF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;                       // edge t
    start = 1'b0;
    @(posedge clk);                           // edge t+1
    @(posedge clk);                           // edge t+2
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, cout, overflow} !== 4'b0000 || sum !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got busy=%b done=%b cout=%b ovf=%b sum=%h required all 0",
               busy, done, cout, overflow, sum);
    end
    #2 rst_n = 1'b1;
    held_sum = '0;
    late_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) late_done++;
    end
    n_cmp++;
    if (late_done !== 0) begin
      n_err++;
      $display("FAIL midreset_aborted: got %0d done/busy cycles after reset required 0", late_done);
    end
    exp = ref_add(32'd1, 32'd2, 1'b0);
    drive_op(32'd1, 32'd2, 1'b0, 1'b0, lat, busy_cnt, busy_sum);
    n_cmp++;
    if (lat !== K || {overflow, cout, sum} !== exp) begin
      n_err++;
      $display("FAIL midreset_next_op: got lat=%0d sum=%h required lat=%0d sum=%h", lat, sum, K, exp[W-1:0]);
    end
    held_sum = exp[W-1:0];
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] exp1, exp2;
    int           lat, gap, n_done;
    exp1 = ref_add(32'd10, 32'd20, 1'b0);
    exp2 = ref_add(32'd3, 32'd4, 1'b0);
    a = 32'd10; b = 32'd20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    // start held high in op1's done cycle
    a = 32'd3; b = 32'd4; start = 1'b1;
    n_cmp++;
    if (lat !== K || {overflow, cout, sum} !== exp1) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d sum=%h required lat=%0d sum=%h", lat, sum, K, exp1[W-1:0]);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b after done-cycle start required 1", busy);
    end
    gap = 1;
    n_done = 0;
    while (!done && gap < TMO) begin
      @(posedge clk); #1;
      gap++;
    end
    if (done) n_done++;
    n_cmp++;
    if (gap !== K + 1 || n_done !== 1) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d cycles between done pulses required %0d", gap, K + 1);
    end
    n_cmp++;
    if ({overflow, cout, sum} !== exp2) begin
      n_err++;
      $display("FAIL b2b_second: got sum=%h cout=%b ovf=%b required sum=%h", sum, cout, overflow, exp2[W-1:0]);
    end
    held_sum = exp2[W-1:0];
    @(posedge clk); #1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_arith(24);
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chunked_wide_adder.md
Name: chunked_wide_adder

Overview:
- Multi-cycle wide adder: adds two W = N*K bit operands plus carry-in by stepping one N-bit chunk per cycle through a single N-bit full adder.
- The chunk carry is registered between cycles, trading latency for area.
- Sits directly upstream of result consumers and wraps the team's N-bit full adder as its datapath.
- A start/busy/done handshake controls each operation; the result is held stable until the next operation completes.

Parameters:
- N, 8, chunk width in bits (width of the N-bit adder instance); must be >= 1.
- K, 4, number of chunks; must be >= 1.
- W, N*K, total operand width. Derived localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new add; sampled only when busy=0.
- a  input  W  operand A, captured on the accepted start edge.
- b  input  W  operand B, captured on the accepted start edge.
- cin  input  1  carry-in, captured on the accepted start edge.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse: sum/cout/overflow just updated.
- sum  output  W  held result register.
- cout  output  1  carry out of bit W-1 (held).
- overflow  output  1  two's-complement overflow of the W-bit add (held).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0; done=0; sum=0; cout=0; overflow=0.
  - Internal operand, working-sum, carry and chunk-index registers = 0.
  - Reset mid-operation aborts the operation: no done pulse, and sum is not updated.
- States: IDLE and RUN.
- IDLE:
  - If start=1, then on that edge: capture a, b and cin; carry_r=cin; idx=0; state to RUN; busy=1.
  - Otherwise hold.
- RUN: on each edge, chunk idx is computed as a_r[idx*N +: N] + b_r[idx*N +: N] + carry_r.
  - The chunk sum is written to work_r[idx*N +: N] and the adder cout to carry_r.
  - If idx < K-1: idx increments.
  - If idx == K-1:
    - sum is loaded from work_r with the final chunk merged in, as one atomic write.
    - cout = final chunk carry.
    - overflow = (a_r[W-1]==b_r[W-1]) && (final sum[W-1] != a_r[W-1]).
    - state to IDLE; busy=0; done=1 for exactly one cycle.
- Latency: start accepted at edge t gives done high after edge t+K, and busy high after edges t through t+K-1.
- K=1: done follows one edge after start.
- start while busy=1 is ignored: operands are not re-captured and the running operation is unaffected.
- start=1 in the cycle done=1 (state is IDLE) is accepted, so back-to-back throughput is one operation per K+1 cycles.
- sum, cout and overflow change only on the completion edge. They never show partial chunks and hold indefinitely between operations.
- Arithmetic: unsigned modulo 2^W; the carry out of bit W-1 goes only to cout.
- Chunk index width is clog2(K), minimum 1 bit. idx never exceeds K-1.

Decomposition:
- Shared package/include `adder_pkg`:
  - state encodings ST_IDLE=0, ST_RUN=1;
  - default chunk width and chunk count constants;
  - a clog2 function for the index width.
- One sub-module: the N-bit ripple-carry adder `faNbit_full_adder` (ports X, Y, cin, S, cout), instantiated once.
- Control FSM, operand/working registers and result registers stay in chunked_wide_adder.

Test Plan:
All scenarios use N=8, K=4.
1. a=32'hFFFFFFFF, b=32'h00000001, cin=0, start pulsed at edge t -> busy high t..t+3; done pulses after t+4; sum=32'h00000000, cout=1, overflow=0.
2. a=32'h7FFFFFFF, b=32'h00000001, cin=0 -> sum=32'h80000000, cout=0, overflow=1.
3. a=32'h12345678, b=32'h11111111, cin=1 -> sum=32'h2345678A, cout=0, overflow=0. During busy, sum still shows the previous result.
4. Start op (a=5, b=7); at edge t+2 assert start with a=100, b=100 -> second request ignored; done once with sum=12; no second done.
5. rst_n low for part of cycle t+2 of an op (asynchronous, between edges) -> busy, done, sum, cout and overflow are 0 immediately; no done follows. A subsequent op a=1, b=2 returns sum=3 after 4 cycles.
6. Back-to-back: op1 a=10, b=20; start held high during op1's done cycle with a=3, b=4 -> done after op1 (sum=30), then done again 5 cycles later (sum=7).
